// File: rtl/dmem_lsu.sv
// dmem_lsu
// Data memory plus load/store unit for the MEM stage of the core. It takes one
// request per cycle through a valid/ready handshake. It performs byte-masked
// stores and sign- or zero-extended loads. Every request gets exactly one
// response, in order, READ_LAT cycles after it was accepted. A downstream
// stall freezes the whole response pipeline.
//
// Parameters
//   DEPTH     memory size in 32-bit words (power of two, >= 4)
//   READ_LAT  response latency in cycles (1 or 2)
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset (pipeline only, not the array)
//   req_valid       request present
//   req_ready       request accepted when high together with req_valid
//   req_we          1 = store, 0 = load
//   req_type        000 B, 001 H, 010 W, 100 BU, 101 HU; other codes illegal
//   req_addr        byte address
//   req_wdata       store data, low 8/16/32 bits used according to size
//   rsp_stall       downstream stall, freezes the pipeline
//   rsp_valid       response present (loads and stores)
//   rsp_rdata       extended load data, 0 for stores and faults
//   rsp_misaligned  response faulted on alignment
//   rsp_fault       response faulted on illegal type or out-of-range address
module dmem_lsu #(
    parameter int DEPTH    = 16384,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        rsp_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_fault
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int ADDR_W = IDX_W + 2;

    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_W  = 3'b010;
    localparam logic [2:0] TYPE_BU = 3'b100;
    localparam logic [2:0] TYPE_HU = 3'b101;

    // request side decode
    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             type_illegal;
    logic             out_of_range;
    logic             align_bad;
    logic             req_fault;
    logic             req_mis;
    logic             do_write;
    logic [3:0]       byte_en;
    logic [31:0]      store_data;

    // storage
    logic [31:0] mem [DEPTH];

    // stage 1: registered read word plus what is needed to extract the lane
    logic        s1_valid;
    logic [31:0] s1_word;
    logic [1:0]  s1_lane;
    logic [2:0]  s1_type;
    logic        s1_load;
    logic        s1_mis;
    logic        s1_fault;

    // lane extraction result
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    // The stall blocks new requests as well as freezing the pipeline, so an
    // accepted request always has room to advance.
    assign req_ready = ~rsp_stall & ~rst;
    assign accept    = req_valid & req_ready;
    assign word_idx  = req_addr[ADDR_W-1:2];
    assign lane      = req_addr[1:0];

    // Classify the request. Fault priority is illegal type, then range, then
    // alignment, so at most one of the two fault flags is ever set.
    always_comb begin
        type_illegal = 1'b0;
        align_bad    = 1'b0;
        case (req_type)
            TYPE_B:  type_illegal = 1'b0;
            TYPE_H:  align_bad    = lane[0];
            TYPE_W:  align_bad    = |lane;
            TYPE_BU: type_illegal = req_we;
            TYPE_HU: begin
                type_illegal = req_we;
                align_bad    = lane[0];
            end
            default: type_illegal = 1'b1;
        endcase
        out_of_range = |req_addr[31:ADDR_W];
        req_fault    = type_illegal | out_of_range;
        req_mis      = ~req_fault & align_bad;
        do_write     = accept & req_we & ~req_fault & ~align_bad;
    end

    // Store lane placement. The data is replicated across the word so that each
    // enabled byte lane simply picks up its own slice.
    always_comb begin
        byte_en    = 4'b1111;
        store_data = req_wdata;
        case (req_type)
            TYPE_B: begin
                byte_en    = 4'b0001 << lane;
                store_data = {4{req_wdata[7:0]}};
            end
            TYPE_H: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = req_wdata;
            end
        endcase
    end

    // Memory array with per-byte write enables. It has no reset, so its
    // contents survive rst.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    // Stage 1 captures the word as it was before any write on the same edge.
    // A held load therefore keeps returning the value from its own accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_load  <= 1'b0;
            s1_mis   <= 1'b0;
            s1_fault <= 1'b0;
        end else if (!rsp_stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_word  <= mem[word_idx];
                s1_lane  <= lane;
                s1_type  <= req_type;
                s1_load  <= ~req_we & ~req_fault & ~align_bad;
                s1_mis   <= req_mis;
                s1_fault <= req_fault;
            end
        end
    end

    // Extract and extend the addressed lane. Stores and faulted requests
    // return zero data.
    always_comb begin
        sel_byte = s1_word[{s1_lane, 3'b000} +: 8];
        sel_half = s1_lane[1] ? s1_word[31:16] : s1_word[15:0];
        ext_data = 32'h0;
        if (s1_load) begin
            case (s1_type)
                TYPE_B:  ext_data = {{24{sel_byte[7]}}, sel_byte};
                TYPE_BU: ext_data = {24'h0, sel_byte};
                TYPE_H:  ext_data = {{16{sel_half[15]}}, sel_half};
                TYPE_HU: ext_data = {16'h0, sel_half};
                TYPE_W:  ext_data = s1_word;
                default: ext_data = 32'h0;
            endcase
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            // Single-cycle latency: the extension logic drives the outputs
            // directly. Everything except valid is forced to zero while idle.
            assign rsp_valid      = s1_valid;
            assign rsp_rdata      = s1_valid ? ext_data : 32'h0;
            assign rsp_misaligned = s1_valid & s1_mis;
            assign rsp_fault      = s1_valid & s1_fault;
        end else begin : g_lat2
            logic        s2_valid;
            logic [31:0] s2_rdata;
            logic        s2_mis;
            logic        s2_fault;

            // Second stage re-registers the extended result. Idle slots are
            // stored as zero, so the outputs need no gating.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_rdata <= 32'h0;
                    s2_mis   <= 1'b0;
                    s2_fault <= 1'b0;
                end else if (!rsp_stall) begin
                    s2_valid <= s1_valid;
                    s2_rdata <= s1_valid ? ext_data : 32'h0;
                    s2_mis   <= s1_valid & s1_mis;
                    s2_fault <= s1_valid & s1_fault;
                end
            end

            assign rsp_valid      = s2_valid;
            assign rsp_rdata      = s2_rdata;
            assign rsp_misaligned = s2_mis;
            assign rsp_fault      = s2_fault;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu
// Drives one request stream into two copies of dmem_lsu, one built with
// READ_LAT=1 and one with READ_LAT=2, and checks both against hand-computed
// responses and a small memory model.
module tb_dmem_lsu;

    localparam int DEPTH = 1024;

    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_stall;

    logic        r1_ready, r1_valid, r1_mis, r1_fault;
    logic [31:0] r1_rdata;
    logic        r2_ready, r2_valid, r2_mis, r2_fault;
    logic [31:0] r2_rdata;

    int checks = 0;
    int errors = 0;

    // directed stimulus table, responses packed as {valid, mis, fault, rdata}
    logic        s_valid [32];
    logic        s_we    [32];
    logic [2:0]  s_type  [32];
    logic [31:0] s_addr  [32];
    logic [31:0] s_wdata [32];
    logic [34:0] s_exp   [32];
    logic [34:0] obs1    [33];
    logic [34:0] obs2    [33];
    int          n_stim;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          stl;
    } exp_t;

    always #5 clk = ~clk;

    dmem_lsu #(.DEPTH(DEPTH), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready),
        .req_we(req_we), .req_type(req_type), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_stall(rsp_stall), .rsp_valid(r1_valid),
        .rsp_rdata(r1_rdata), .rsp_misaligned(r1_mis), .rsp_fault(r1_fault)
    );

    dmem_lsu #(.DEPTH(DEPTH), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r2_ready),
        .req_we(req_we), .req_type(req_type), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_stall(rsp_stall), .rsp_valid(r2_valid),
        .rsp_rdata(r2_rdata), .rsp_misaligned(r2_mis), .rsp_fault(r2_fault)
    );

    task automatic add_req(input logic we, input logic [2:0] typ,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] erd, input logic emis,
                           input logic efault);
        s_valid[n_stim] = 1'b1;
        s_we[n_stim]    = we;
        s_type[n_stim]  = typ;
        s_addr[n_stim]  = addr;
        s_wdata[n_stim] = wdata;
        s_exp[n_stim]   = {1'b1, emis, efault, erd};
        n_stim++;
    endtask

    task automatic add_idle();
        s_valid[n_stim] = 1'b0;
        s_we[n_stim]    = 1'b0;
        s_type[n_stim]  = T_W;
        s_addr[n_stim]  = 32'h0;
        s_wdata[n_stim] = 32'h0;
        s_exp[n_stim]   = 35'h0;
        n_stim++;
    endtask

    // Plays the table back-to-back and records both DUTs' outputs #1 after each
    // edge. The READ_LAT=1 response to entry t is in obs1[t], and the
    // READ_LAT=2 response is in obs2[t+1].
    task automatic apply_stimulus(input int n);
        for (int t = 0; t <= n; t++) begin
            if (t < n) begin
                req_valid = s_valid[t];
                req_we    = s_we[t];
                req_type  = s_type[t];
                req_addr  = s_addr[t];
                req_wdata = s_wdata[t];
            end else begin
                req_valid = 1'b0;
                req_we    = 1'b0;
            end
            @(posedge clk);
            #1;
            obs1[t] = {r1_valid, r1_mis, r1_fault, r1_rdata};
            obs2[t] = {r2_valid, r2_mis, r2_fault, r2_rdata};
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_stall = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_type  = T_W;
        req_addr  = 32'h300;
        req_wdata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (r1_ready !== 1'b0 || r2_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset ready cyc%0d: got %b/%b expected 0/0", k, r1_ready, r2_ready);
            end
            checks++;
            if ({r1_valid, r1_mis, r1_fault, r1_rdata} !== 35'h0 ||
                {r2_valid, r2_mis, r2_fault, r2_rdata} !== 35'h0) begin
                errors++;
                $display("[TB] FAIL reset outputs cyc%0d: got %h / %h expected 0",
                         k, {r1_valid, r1_mis, r1_fault, r1_rdata}, {r2_valid, r2_mis, r2_fault, r2_rdata});
            end
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        #1;
        checks++;
        if (r1_ready !== 1'b1 || r2_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready after reset: got %b/%b expected 1/1", r1_ready, r2_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_word();
        n_stim = 0;
        add_req(1'b1, T_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        add_req(1'b0, T_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        add_idle();
        add_req(1'b0, T_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        add_req(1'b1, T_W, 32'h100, 32'h01020304, 32'h0, 1'b0, 1'b0);
        add_req(1'b0, T_W, 32'h100, 32'h0, 32'h01020304, 1'b0, 1'b0);
        apply_stimulus(n_stim);
        for (int t = 0; t < n_stim; t++) begin
            checks++;
            if (obs1[t] !== s_exp[t]) begin
                errors++;
                $display("[TB] FAIL word lat1 #%0d: got %h expected %h", t, obs1[t], s_exp[t]);
            end
            checks++;
            if (obs2[t+1] !== s_exp[t]) begin
                errors++;
                $display("[TB] FAIL word lat2 #%0d: got %h expected %h", t, obs2[t+1], s_exp[t]);
            end
        end
    endtask

    task automatic test_lanes();
        n_stim = 0;
        add_req(1'b1, T_W,  32'h40, 32'h11223344, 32'h0, 1'b0, 1'b0);
        add_req(1'b1, T_B,  32'h42, 32'h555555AA, 32'h0, 1'b0, 1'b0);
        add_req(1'b1, T_H,  32'h40, 32'h1234BEEF, 32'h0, 1'b0, 1'b0);
        add_req(1'b0, T_W,  32'h40, 32'h0, 32'h11AABEEF, 1'b0, 1'b0);
        add_req(1'b0, T_B,  32'h42, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0);
        add_req(1'b0, T_BU, 32'h42, 32'h0, 32'h000000AA, 1'b0, 1'b0);
        add_req(1'b0, T_H,  32'h40, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b0);
        add_req(1'b0, T_HU, 32'h40, 32'h0, 32'h0000BEEF, 1'b0, 1'b0);
        add_req(1'b0, T_B,  32'h43, 32'h0, 32'h00000011, 1'b0, 1'b0);
        add_req(1'b0, T_H,  32'h42, 32'h0, 32'h000011AA, 1'b0, 1'b0);
        add_req(1'b0, T_BU, 32'h41, 32'h0, 32'h000000BE, 1'b0, 1'b0);
        add_req(1'b0, T_B,  32'h40, 32'h0, 32'hFFFFFFEF, 1'b0, 1'b0);
        add_req(1'b1, T_H,  32'h42, 32'hAAAA7F80, 32'h0, 1'b0, 1'b0);
        add_req(1'b0, T_H,  32'h42, 32'h0, 32'h00007F80, 1'b0, 1'b0);
        add_req(1'b0, T_B,  32'h42, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
        add_req(1'b0, T_HU, 32'h42, 32'h0, 32'h00007F80, 1'b0, 1'b0);
        add_req(1'b0, T_B,  32'h43, 32'h0, 32'h0000007F, 1'b0, 1'b0);
        add_req(1'b0, T_W,  32'h40, 32'h0, 32'h7F80BEEF, 1'b0, 1'b0);
        apply_stimulus(n_stim);
        for (int t = 0; t < n_stim; t++) begin
            checks++;
            if (obs1[t] !== s_exp[t]) begin
                errors++;
                $display("[TB] FAIL lanes lat1 #%0d: got %h expected %h", t, obs1[t], s_exp[t]);
            end
            checks++;
            if (obs2[t+1] !== s_exp[t]) begin
                errors++;
                $display("[TB] FAIL lanes lat2 #%0d: got %h expected %h", t, obs2[t+1], s_exp[t]);
            end
        end
    endtask

    task automatic test_faults();
        n_stim = 0;
        add_req(1'b1, T_W,    32'h100,  32'h55667788, 32'h0, 1'b0, 1'b0);
        add_req(1'b1, T_W,    32'h104,  32'h0BADF00D, 32'h0, 1'b0, 1'b0);
        add_req(1'b0, T_H,    32'h41,   32'h0,        32'h0, 1'b1, 1'b0);
        add_req(1'b1, T_W,    32'h102,  32'hCAFEBABE, 32'h0, 1'b1, 1'b0);
        add_req(1'b0, T_W,    32'h100,  32'h0, 32'h55667788, 1'b0, 1'b0);
        add_req(1'b0, 3'b011, 32'h100,  32'h0,        32'h0, 1'b0, 1'b1);
        add_req(1'b0, T_W,    32'h1000, 32'h0,        32'h0, 1'b0, 1'b1);
        add_req(1'b1, T_HU,   32'h104,  32'h00001234, 32'h0, 1'b0, 1'b1);
        add_req(1'b0, T_W,    32'h104,  32'h0, 32'h0BADF00D, 1'b0, 1'b0);
        add_req(1'b1, T_BU,   32'h104,  32'h000000EE, 32'h0, 1'b0, 1'b1);
        add_req(1'b0, T_W,    32'h104,  32'h0, 32'h0BADF00D, 1'b0, 1'b0);
        add_req(1'b1, 3'b111, 32'h103,  32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        add_req(1'b0, T_H,    32'h1001, 32'h0,        32'h0, 1'b0, 1'b1);
        add_req(1'b0, 3'b110, 32'h100,  32'h0,        32'h0, 1'b0, 1'b1);
        add_req(1'b0, T_HU,   32'h43,   32'h0,        32'h0, 1'b1, 1'b0);
        add_req(1'b0, T_W,    32'h100,  32'h0, 32'h55667788, 1'b0, 1'b0);
        apply_stimulus(n_stim);
        for (int t = 0; t < n_stim; t++) begin
            checks++;
            if (obs1[t] !== s_exp[t]) begin
                errors++;
                $display("[TB] FAIL faults lat1 #%0d: got %h expected %h", t, obs1[t], s_exp[t]);
            end
            checks++;
            if (obs2[t+1] !== s_exp[t]) begin
                errors++;
                $display("[TB] FAIL faults lat2 #%0d: got %h expected %h", t, obs2[t+1], s_exp[t]);
            end
        end
    endtask

    task automatic test_stall();
        logic [34:0] e1 [8];
        logic [34:0] e2 [8];
        logic [34:0] pa, pb, pc;
        logic        exp_ready;
        pa = {3'b100, 32'hAAAA0001};
        pb = {3'b100, 32'hBBBB0002};
        pc = {3'b100, 32'hCCCC0003};
        n_stim = 0;
        add_req(1'b1, T_W, 32'h200, 32'hAAAA0001, 32'h0, 1'b0, 1'b0);
        add_req(1'b1, T_W, 32'h204, 32'hBBBB0002, 32'h0, 1'b0, 1'b0);
        add_req(1'b1, T_W, 32'h208, 32'hCCCC0003, 32'h0, 1'b0, 1'b0);
        apply_stimulus(n_stim);
        e1 = '{pa, pb, pb, pb, pb, pc, 35'h0, 35'h0};
        e2 = '{35'h0, pa, pa, pa, pa, pb, pc, 35'h0};
        for (int k = 0; k < 8; k++) begin
            req_valid = (k <= 5);
            req_we    = 1'b0;
            req_type  = T_W;
            req_addr  = (k == 0) ? 32'h200 : (k == 1) ? 32'h204 : 32'h208;
            rsp_stall = (k >= 2 && k <= 4);
            exp_ready = !(k >= 2 && k <= 4);
            #1;
            checks++;
            if (r1_ready !== exp_ready || r2_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL stall ready cyc%0d: got %b/%b expected %b", k, r1_ready, r2_ready, exp_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({r1_valid, r1_mis, r1_fault, r1_rdata} !== e1[k]) begin
                errors++;
                $display("[TB] FAIL stall lat1 cyc%0d: got %h expected %h", k, {r1_valid, r1_mis, r1_fault, r1_rdata}, e1[k]);
            end
            checks++;
            if ({r2_valid, r2_mis, r2_fault, r2_rdata} !== e2[k]) begin
                errors++;
                $display("[TB] FAIL stall lat2 cyc%0d: got %h expected %h", k, {r2_valid, r2_mis, r2_fault, r2_rdata}, e2[k]);
            end
        end
        req_valid = 1'b0;
        rsp_stall = 1'b0;
    endtask

    task automatic test_reset_mid_flight();
        logic [34:0] pl;
        pl = {3'b100, 32'h13579BDF};
        n_stim = 0;
        add_req(1'b1, T_W, 32'h300, 32'h13579BDF, 32'h0, 1'b0, 1'b0);
        apply_stimulus(n_stim);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_type  = T_W;
        req_addr  = 32'h300;
        @(posedge clk);
        #1;
        checks++;
        if ({r1_valid, r1_mis, r1_fault, r1_rdata} !== pl) begin
            errors++;
            $display("[TB] FAIL rstmid first load lat1: got %h expected %h", {r1_valid, r1_mis, r1_fault, r1_rdata}, pl);
        end
        @(posedge clk);
        #1;
        checks++;
        if (r1_valid !== 1'b1 || r2_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid in flight: got valid %b/%b expected 1/1", r1_valid, r2_valid);
        end
        rst       = 1'b1;
        req_we    = 1'b1;
        req_wdata = 32'hFFFFFFFF;
        #1;
        checks++;
        if (r1_ready !== 1'b0 || r2_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid ready: got %b/%b expected 0/0", r1_ready, r2_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            rst       = 1'b0;
            req_valid = 1'b0;
            req_we    = 1'b0;
            checks++;
            if ({r1_valid, r1_mis, r1_fault, r1_rdata} !== 35'h0 ||
                {r2_valid, r2_mis, r2_fault, r2_rdata} !== 35'h0) begin
                errors++;
                $display("[TB] FAIL rstmid flush cyc%0d: got %h / %h expected 0",
                         k, {r1_valid, r1_mis, r1_fault, r1_rdata}, {r2_valid, r2_mis, r2_fault, r2_rdata});
            end
        end
        n_stim = 0;
        add_req(1'b0, T_W, 32'h300, 32'h0, 32'h13579BDF, 1'b0, 1'b0);
        apply_stimulus(n_stim);
        checks++;
        if (obs1[0] !== s_exp[0] || obs2[1] !== s_exp[0]) begin
            errors++;
            $display("[TB] FAIL rstmid readback: got %h / %h expected %h", obs1[0], obs2[1], s_exp[0]);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] model [16];
        exp_t        q1 [$];
        exp_t        q2 [$];
        exp_t        e;
        int          edge_no     = 0;
        int          stall_total = 0;
        int          issued      = 0;
        bit          have        = 1'b0;
        bit          done        = 1'b0;
        n_stim = 0;
        for (int w = 0; w < 16; w++) begin
            model[w] = 32'hA5000000 | 32'(w);
            add_req(1'b1, T_W, 32'h400 + 32'(w * 4), model[w], 32'h0, 1'b0, 1'b0);
        end
        apply_stimulus(n_stim);
        for (int c = 0; c < 2000 && !done; c++) begin
            @(posedge clk);
            edge_no++;
            #1;
            if (!have) begin
                if (issued < 64) begin
                    req_valid = 1'b1;
                    req_we    = (issued % 2 == 0);
                    req_type  = T_W;
                    req_addr  = 32'h400 + ($urandom_range(0, 15) << 2);
                    req_wdata = $urandom;
                    have      = 1'b1;
                    issued++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            rsp_stall = ($urandom_range(0, 99) < 20);
            @(negedge clk);
            if (req_valid && r1_ready) begin
                e.acc = edge_no + 1;
                e.stl = stall_total;
                if (req_we) begin
                    model[req_addr[5:2]] = req_wdata;
                    e.data = 32'h0;
                end else begin
                    e.data = model[req_addr[5:2]];
                end
                q1.push_back(e);
                q2.push_back(e);
                have = 1'b0;
            end
            if (r1_valid && !rsp_stall) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stream lat1 spurious: got data %h expected no response", r1_rdata);
                end else begin
                    e = q1.pop_front();
                    if ({r1_mis, r1_fault, r1_rdata} !== {2'b00, e.data} ||
                        (edge_no + 1 - e.acc) != 1 + (stall_total - e.stl)) begin
                        errors++;
                        $display("[TB] FAIL stream lat1: got data %h lat %0d expected data %h lat %0d",
                                 r1_rdata, edge_no + 1 - e.acc, e.data, 1 + stall_total - e.stl);
                    end
                end
            end
            if (r2_valid && !rsp_stall) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stream lat2 spurious: got data %h expected no response", r2_rdata);
                end else begin
                    e = q2.pop_front();
                    if ({r2_mis, r2_fault, r2_rdata} !== {2'b00, e.data} ||
                        (edge_no + 1 - e.acc) != 2 + (stall_total - e.stl)) begin
                        errors++;
                        $display("[TB] FAIL stream lat2: got data %h lat %0d expected data %h lat %0d",
                                 r2_rdata, edge_no + 1 - e.acc, e.data, 2 + stall_total - e.stl);
                    end
                end
            end
            if (rsp_stall) stall_total++;
            if (issued == 64 && !have && q1.size() == 0 && q2.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL stream timeout: got %0d issued, %0d/%0d pending, expected 64 issued, 0 pending",
                     issued, q1.size(), q2.size());
        end
        @(posedge clk);
        #1;
        rsp_stall = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_type  = T_W;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_stall = 1'b0;
        test_reset();
        test_word();
        test_lanes();
        test_faults();
        test_stall();
        test_reset_mid_flight();
        test_streaming();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, pipelined data memory with load/store unit for the MEM stage of the RISC-V core. Handles byte, halfword and word stores with byte-lane masking, and sign- or zero-extended loads with lane extraction by address. Checks alignment, illegal access types and address range, with a configurable read latency and a valid/ready request handshake. A stall input freezes the response pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.

## Interface
- DEPTH, 16384, memory size in 32-bit words; power of two, ≥ 4
- READ_LAT, 1, load/store response latency in cycles; legal values 1 or 2
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_we  in  1  1 = store, 0 = load
- req_type  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; all other codes illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low 8/16/32 bits used according to size
- rsp_stall  in  1  downstream stall; freezes the pipeline
- rsp_valid  out  1  response present (loads and stores)
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_misaligned  out  1  response faulted on alignment
- rsp_fault  out  1  response faulted on illegal type or out-of-range address

## Operation
- Accept condition: accept = req_valid & req_ready, where req_ready = ~rsp_stall & ~rst.
- Word index = req_addr[log2(DEPTH)+1:2]. Lane = req_addr[1:0].
- Out-of-range fault: any of req_addr[31:log2(DEPTH)+2] is nonzero.
- Misaligned fault:
  - H, HU with addr[0] = 1
  - W with addr[1:0] ≠ 0
  - B and BU are never misaligned.
- Illegal-type fault:
  - req_type ∈ {011, 110, 111}
  - also any store with type BU or HU
- Fault priority: illegal type > out of range > misaligned. Only one of rsp_fault / rsp_misaligned is asserted.
- A faulting request produces no memory write. Its response has rsp_rdata = 0.
- Store (no fault): on the accept edge, write lane(s) of the addressed word.
  - B: byte at lane ← wdata[7:0]
  - H: bytes lane..lane+1 ← wdata[15:0]
  - W: whole word
  - Other bytes of the word are unchanged (per-byte write enables).
- Load (no fault): the word is read and registered on the accept edge. The lane is extracted from the registered word using the registered addr[1:0].
  - B, H sign-extend from bit 7 / bit 15.
  - BU, HU zero-extend.
  - W passes the word through unchanged.
- Memory array has no reset; its contents are undefined until written. Array contents survive rst.
- rst clears all pipeline valid bits. Pending responses are discarded. A request presented while rst is high is not accepted and causes no write.

## Timing
- Reset values: req_ready 0 (during rst), rsp_valid 0, rsp_rdata 0, rsp_misaligned 0, rsp_fault 0.
- Latency without stall: rsp_valid is asserted exactly READ_LAT cycles after the accept edge.
  - READ_LAT = 1: the extension logic feeds the outputs combinationally from the stage-1 register.
  - READ_LAT = 2: the extended result is registered once more.
- Throughput: one request per cycle. Back-to-back requests yield back-to-back responses in order.
- rsp_stall = 1:
  - No accept.
  - All stage registers, including the read-data register, hold.
  - Outputs hold their current values; rsp_valid stays asserted if it was high.
- Read-after-write: a store accepted in cycle N is visible to a load accepted in cycle N+1 or later. Only one request is accepted per cycle, so there is no same-cycle collision.
- When stalled, a held load returns the value read at its accept edge, even if the word is later overwritten.
- Outputs other than rsp_valid are 0 whenever rsp_valid = 0.

## Test plan
- Word store/load, READ_LAT=1: SW 0xDEADBEEF @0x100, then LW @0x100 next cycle → rsp_valid at +1 with rdata 0xDEADBEEF, no faults.
- Lane masking: SW 0x11223344 @0x40, SB 0xAA @0x42, SH 0xBEEF @0x40; then LW @0x40 → 0x11AABEEF. LB @0x42 → 0xFFFFFFAA. LBU @0x42 → 0x000000AA. LH @0x40 → 0xFFFFBEEF. LHU @0x40 → 0x0000BEEF.
- Faults:
  - LH @0x41 → rsp_misaligned=1, rdata 0.
  - SW @0x102 → misaligned, and a later LW @0x100 shows the old value.
  - req_type 011 → rsp_fault=1.
  - LW @DEPTH*4 → rsp_fault=1.
  - SHU (store, type 101) → rsp_fault=1 with no write.
- Stall, READ_LAT=2: issue loads A, B, C back-to-back, then raise rsp_stall for 3 cycles while A's response is valid → outputs hold A and req_ready=0. After release, A, B, C complete in order with no loss or duplication.
- Reset mid-flight: accept two loads, assert rst for 1 cycle → rsp_valid=0 next cycle and no stale response appears later. Memory contents written before reset read back intact after it.
- Streaming: 64 alternating SW/LW to random aligned addresses, 20% random stalls → every load matches the scoreboard, and latency equals READ_LAT plus the stall cycles.
